onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter_if.sv | 50 +++++
 rtl/onchip_mem_arbiter.sv | 104 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between two Avalon-style masters, the arbiter and a single-port RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]     m0_address;
  logic [(DATA_W/8)-1:0] m0_byteenable;
  logic                  m0_read;
  logic                  m0_write;
  logic [DATA_W-1:0]     m0_writedata;
  logic                  m0_waitrequest;
  logic [DATA_W-1:0]     m0_readdata;
  logic                  m0_readdatavalid;

  logic [ADDR_W-1:0]     m1_address;
  logic [(DATA_W/8)-1:0] m1_byteenable;
  logic                  m1_read;
  logic                  m1_write;
  logic [DATA_W-1:0]     m1_writedata;
  logic                  m1_waitrequest;
  logic [DATA_W-1:0]     m1_readdata;
  logic                  m1_readdatavalid;

  logic [ADDR_W-1:0]     mem_address;
  logic [(DATA_W/8)-1:0] mem_byteenable;
  logic [DATA_W-1:0]     mem_writedata;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic                  mem_clken;
  logic [DATA_W-1:0]     mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM with fixed one-cycle read latency.
// Define ONCHIP_ARB_FIXED_PRIO_EN for m0-always-wins priority; default is round-robin.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  onchip_mem_arbiter_if.slave  bus
);

  logic req0_s;
  logic req1_s;
  logic gnt0_s;
  logic gnt1_s;
  logic rd_tag_valid_r;
  logic rd_tag_id_r;
`ifndef ONCHIP_ARB_FIXED_PRIO_EN
  logic last_grant_r;
`endif

  assign req0_s = bus.m0_read | bus.m0_write;
  assign req1_s = bus.m1_read | bus.m1_write;

  // Grant decision for the current cycle; nothing is granted while reset is high.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_s && req1_s) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      gnt0_s = 1'b1;
`else
      if (last_grant_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
`endif
    end else if (req0_s) begin
      gnt0_s = 1'b1;
    end else if (req1_s) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Forward the winner's command to the RAM port.
  always_comb begin
    bus.mem_address    = bus.m0_address;
    bus.mem_byteenable = bus.m0_byteenable;
    bus.mem_writedata  = bus.m0_writedata;
    bus.mem_write      = 1'b0;
    if (gnt1_s) begin
      bus.mem_address    = bus.m1_address;
      bus.mem_byteenable = bus.m1_byteenable;
      bus.mem_writedata  = bus.m1_writedata;
      bus.mem_write      = bus.m1_write;
    end else if (gnt0_s) begin
      bus.mem_write      = bus.m0_write;
    end else begin
      bus.mem_write      = 1'b0;
    end
  end

  assign bus.mem_chipselect   = gnt0_s | gnt1_s;
  assign bus.mem_clken        = 1'b1;
  assign bus.m0_waitrequest   = ~gnt0_s;
  assign bus.m1_waitrequest   = ~gnt1_s;
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  // Reset also masks the tag so a read accepted just before reset never returns.
  assign bus.m0_readdatavalid = rd_tag_valid_r & ~rd_tag_id_r & ~reset;
  assign bus.m1_readdatavalid = rd_tag_valid_r &  rd_tag_id_r & ~reset;

  // Read-owner tag: set for exactly the cycle after an accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag_valid_r <= 1'b0;
      rd_tag_id_r    <= 1'b0;
    end else begin
      rd_tag_valid_r <= (gnt0_s & ~bus.m0_write) | (gnt1_s & ~bus.m1_write);
      rd_tag_id_r    <= gnt1_s;
    end
  end

`ifndef ONCHIP_ARB_FIXED_PRIO_EN
  // Remembers who was granted last; starts at m1 so m0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (gnt0_s || gnt1_s) begin
      last_grant_r <= gnt1_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: bench-side RAM, a cycle model of the
// arbitration rules checked every cycle, and literal checks for the key scenarios.
module tb_onchip_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ram     [0:8191];
  logic [31:0] mdl_mem [0:8191];
  logic [31:0] ram_q = 32'h0;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM with one-cycle registered read, driven only by the arbiter's mem_* port
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) ram[bus.mem_address] <= merge(ram[bus.mem_address], bus.mem_writedata, bus.mem_byteenable);
      else ram_q <= ram[bus.mem_address];
    end
  end
  assign bus.mem_readdata = ram_q;

  // Reference model: grants, forwarding and read returns derived from the rules
  int          last_m = 1;
  bit          pend_v = 1'b0;
  int          pend_owner = 0;
  logic [31:0] pend_data = 32'h0;
  initial begin
    bit r0, r1, wr;
    int win;
    logic [12:0] a;
    forever begin
      @(negedge clk);
      r0 = bus.m0_read | bus.m0_write;
      r1 = bus.m1_read | bus.m1_write;
      if (reset) win = -1;
      else if (r0 && r1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = (last_m == 0) ? 1 : 0;
`endif
      end
      else if (r0) win = 0;
      else if (r1) win = 1;
      else win = -1;
      chk("m0_waitrequest", {31'h0, bus.m0_waitrequest}, {31'h0, win != 0});
      chk("m1_waitrequest", {31'h0, bus.m1_waitrequest}, {31'h0, win != 1});
      chk("mem_chipselect", {31'h0, bus.mem_chipselect}, {31'h0, win >= 0});
      chk("mem_clken", {31'h0, bus.mem_clken}, 32'h1);
      wr = (win == 0) ? bus.m0_write : (win == 1) ? bus.m1_write : 1'b0;
      chk("mem_write", {31'h0, bus.mem_write}, {31'h0, wr});
      if (win == 0) begin
        chk("mem_address", {19'h0, bus.mem_address}, {19'h0, bus.m0_address});
        chk("mem_byteenable", {28'h0, bus.mem_byteenable}, {28'h0, bus.m0_byteenable});
        chk("mem_writedata", bus.mem_writedata, bus.m0_writedata);
      end else if (win == 1) begin
        chk("mem_address", {19'h0, bus.mem_address}, {19'h0, bus.m1_address});
        chk("mem_byteenable", {28'h0, bus.mem_byteenable}, {28'h0, bus.m1_byteenable});
        chk("mem_writedata", bus.mem_writedata, bus.m1_writedata);
      end
      chk("m0_readdatavalid", {31'h0, bus.m0_readdatavalid}, {31'h0, !reset && pend_v && pend_owner == 0});
      chk("m1_readdatavalid", {31'h0, bus.m1_readdatavalid}, {31'h0, !reset && pend_v && pend_owner == 1});
      if (!reset && pend_v && pend_owner == 0) chk("m0_readdata", bus.m0_readdata, pend_data);
      if (!reset && pend_v && pend_owner == 1) chk("m1_readdata", bus.m1_readdata, pend_data);
      // advance model state to the next cycle
      pend_v = 1'b0;
      if (reset) last_m = 1;
      else if (win >= 0) begin
        last_m = win;
        a = (win == 0) ? bus.m0_address : bus.m1_address;
        if (wr) mdl_mem[a] = merge(mdl_mem[a], (win == 0) ? bus.m0_writedata : bus.m1_writedata,
                                   (win == 0) ? bus.m0_byteenable : bus.m1_byteenable);
        else begin
          pend_v = 1'b1;
          pend_owner = win;
          pend_data = mdl_mem[a];
        end
      end
    end
  end

  task automatic idle();
    bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_address = 13'h0; bus.m0_byteenable = 4'h0; bus.m0_writedata = 32'h0;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_address = 13'h0; bus.m1_byteenable = 4'h0; bus.m1_writedata = 32'h0;
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_byteenable = be; bus.m0_writedata = d;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_byteenable = be; bus.m1_writedata = d;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int g_seq [0:7];
  int rdv_seq [0:7];
  int exp_g;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 32'h0;
      mdl_mem[i] = 32'h0;
    end
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_wait0", {31'h0, bus.m0_waitrequest}, 32'h1);
    chk("rst_wait1", {31'h0, bus.m1_waitrequest}, 32'h1);
    chk("rst_cs", {31'h0, bus.mem_chipselect}, 32'h0);
    chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_wait", {30'h0, bus.m0_waitrequest, bus.m1_waitrequest}, 32'h3);
    chk("idle_cs", {31'h0, bus.mem_chipselect}, 32'h0);
    chk("idle_rdv", {30'h0, bus.m0_readdatavalid, bus.m1_readdatavalid}, 32'h0);

    // m0 writes DEADBEEF, m1 reads it back
    next_cycle(); drive(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_m0_wait", {31'h0, bus.m0_waitrequest}, 32'h0);
    chk("wr_mem_write", {31'h0, bus.mem_write}, 32'h1);
    next_cycle(); idle(); drive(1, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("rd_m1_wait", {31'h0, bus.m1_waitrequest}, 32'h0);
    next_cycle(); idle();
    @(negedge clk);
    chk("rd_m1_rdv", {31'h0, bus.m1_readdatavalid}, 32'h1);
    chk("rd_m1_data", bus.m1_readdata, 32'hDEADBEEF);
    chk("rd_m0_rdv", {31'h0, bus.m0_readdatavalid}, 32'h0);

    // partial write at the top address
    next_cycle(); drive(1, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'hFFFFFFFF);
    next_cycle(); drive(1, 1'b0, 1'b1, 13'h1FFF, 4'h3, 32'h12345678);
    next_cycle(); drive(1, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
    next_cycle(); idle();
    @(negedge clk);
    chk("be_rdv", {31'h0, bus.m1_readdatavalid}, 32'h1);
    chk("be_data", bus.m1_readdata, 32'hFFFF5678);

    // both masters read continuously
    next_cycle();
    drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g_seq[i]   = (!bus.m0_waitrequest) ? 0 : (!bus.m1_waitrequest) ? 1 : 2;
      rdv_seq[i] = bus.m0_readdatavalid ? 0 : bus.m1_readdatavalid ? 1 : 2;
      next_cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      chk("contend_grant", g_seq[i], exp_g);
      if (i > 0) chk("contend_rdv_owner", rdv_seq[i], g_seq[i-1]);
    end

    // read+write together counts as a write; contention with an m1 write
    drive(0, 1'b1, 1'b1, 13'h0030, 4'hF, 32'hAAAA5555);
    drive(1, 1'b0, 1'b1, 13'h0031, 4'hF, 32'h00000001);
    @(negedge clk);
    chk("rw_grant_m0", {31'h0, bus.m0_waitrequest}, 32'h0);
    chk("rw_is_write", {31'h0, bus.mem_write}, 32'h1);
    next_cycle(); drive(0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rw_grant_m1", {31'h0, bus.m1_waitrequest}, 32'h0);
    next_cycle(); idle(); drive(0, 1'b1, 1'b0, 13'h0030, 4'hF, 32'h0);
    next_cycle(); idle();
    @(negedge clk);
    chk("rw_readback", bus.m0_readdata, 32'hAAAA5555);

    // reset right after an accepted read drops its return
    next_cycle(); drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("rst_rd_accept", {31'h0, bus.m0_waitrequest}, 32'h0);
    next_cycle(); idle(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_drop_rdv", {31'h0, bus.m0_readdatavalid}, 32'h0);
    end
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdv", {31'h0, bus.m0_readdatavalid}, 32'h0);
    next_cycle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
